// File: rtl/jelly3_carry_pipeline_pkg.sv
// Shared types and helpers for the segmented carry-pipeline adder.
package jelly3_carry_pipeline_pkg;

  // Widest operand the stage record can carry; bits above DATA_BITS stay zero.
  localparam int REC_BITS = 64;

  typedef struct packed {
    logic                valid;
    logic [REC_BITS-1:0] p;
    logic [REC_BITS-1:0] d;
    logic [REC_BITS-1:0] sum;
    logic                carry;
  } stage_t;

  function automatic int calc_n_seg(input int data_bits, input int seg_bits);
    return (data_bits + seg_bits - 1) / seg_bits;
  endfunction

endpackage

// File: rtl/jelly3_carry_pipeline_segment.sv
// One pipeline stage: resolves the carry across segment SEG_IDX and registers the record.
module jelly3_carry_pipeline_segment
  import jelly3_carry_pipeline_pkg::*;
#(
  parameter int    DATA_BITS = 32,
  parameter int    SEG_BITS  = 8,
  parameter int    SEG_IDX   = 0,
  parameter string DEVICE    = "RTL"
) (
  input  logic   clk,
  input  logic   aresetn,
  input  logic   en,
  input  stage_t in_rec,
  output stage_t out_rec
);

  localparam int LO = SEG_IDX * SEG_BITS;
  localparam int HI = (LO + SEG_BITS > DATA_BITS) ? DATA_BITS - 1 : LO + SEG_BITS - 1;
  localparam int W  = HI - LO + 1;

  logic [W-1:0] p_seg;
  logic [W-1:0] d_seg;
  logic [W-1:0] sum_seg;
  logic         cout;

  assign p_seg = in_rec.p[HI:LO];
  assign d_seg = in_rec.d[HI:LO];

  if (DEVICE == "RTL") begin : g_rtl
    logic c;
    always_comb begin
      c       = in_rec.carry;
      sum_seg = '0;
      for (int i = 0; i < W; i++) begin
        sum_seg[i] = c ^ p_seg[i];
        c          = p_seg[i] ? c : d_seg[i];
      end
      cout = c;
    end
  end else begin : g_dev
    // d is operand A and d^p is the (possibly inverted) B, so a plain adder maps onto vendor carry chains.
    logic [W:0] add;
    assign add     = {1'b0, d_seg} + {1'b0, d_seg ^ p_seg} + {{W{1'b0}}, in_rec.carry};
    assign sum_seg = add[W-1:0];
    assign cout    = add[W];
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      out_rec <= '0;
    end else if (en) begin
      out_rec             <= in_rec;
      out_rec.sum[HI:LO]  <= sum_seg;
      out_rec.carry       <= cout;
    end
  end

endmodule

// File: rtl/jelly3_carry_pipeline_adder.sv
// Pipelined adder/subtractor resolving SEG_BITS of carry per stage, latency N_SEG.
// Optional JELLY3_CARRY_PIPELINE_ADDER_SKID_EN adds a 2-entry input skid buffer (registered s_ready, latency +1).
module jelly3_carry_pipeline_adder
  import jelly3_carry_pipeline_pkg::*;
#(
  parameter int    DATA_BITS = 32,
  parameter int    SEG_BITS  = 8,
  parameter string DEVICE    = "RTL"
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [DATA_BITS-1:0] s_a,
  input  logic [DATA_BITS-1:0] s_b,
  input  logic                 s_cin,
  input  logic                 s_sub,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DATA_BITS-1:0] m_sum,
  output logic                 m_carry,
  output logic                 m_overflow,
  output logic                 m_valid,
  input  logic                 m_ready
);

  localparam int N_SEG = calc_n_seg(DATA_BITS, SEG_BITS);
  localparam int OP_W  = 2 * DATA_BITS + 2;

  logic                 en;
  logic [DATA_BITS-1:0] in_a;
  logic [DATA_BITS-1:0] in_b;
  logic                 in_cin;
  logic                 in_sub;
  logic                 in_valid;
  stage_t               head;
  stage_t               rec [N_SEG+1];
  stage_t               last_unused;

  assign en = m_ready || !m_valid;

`ifdef JELLY3_CARRY_PIPELINE_ADDER_SKID_EN
  logic [1:0]      cnt;
  logic [1:0]      cnt_next;
  logic            ready_q;
  logic            push;
  logic            pop;
  logic            wr_idx;
  logic [OP_W-1:0] slot [2];

  assign push     = s_valid && ready_q;
  assign pop      = en && (cnt != 2'd0);
  assign cnt_next = cnt + {1'b0, push} - {1'b0, pop};
  assign wr_idx   = (cnt == 2'd2) || ((cnt == 2'd1) && !pop);
  assign s_ready  = ready_q;
  assign in_valid = (cnt != 2'd0);
  assign {in_a, in_b, in_cin, in_sub} = slot[0];

  // Head always sits in slot 0; a pop shifts slot 1 down before any push lands.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt     <= 2'd0;
      ready_q <= 1'b0;
      slot[0] <= '0;
      slot[1] <= '0;
    end else begin
      cnt     <= cnt_next;
      ready_q <= (cnt_next != 2'd2);
      if (pop)  slot[0]      <= slot[1];
      if (push) slot[wr_idx] <= {s_a, s_b, s_cin, s_sub};
    end
  end
`else
  assign s_ready  = aresetn && en;
  assign in_valid = s_valid;
  assign in_a     = s_a;
  assign in_b     = s_b;
  assign in_cin   = s_cin;
  assign in_sub   = s_sub;
`endif

  always_comb begin
    head                    = '0;
    head.valid              = in_valid;
    head.p[DATA_BITS-1:0]   = in_a ^ (in_sub ? ~in_b : in_b);
    head.d[DATA_BITS-1:0]   = in_a;
    head.carry              = in_sub | in_cin;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rec[0] <= '0;
    end else if (en) begin
      rec[0] <= head;
    end
  end

  for (genvar k = 0; k < N_SEG; k++) begin : g_seg
    jelly3_carry_pipeline_segment #(
      .DATA_BITS (DATA_BITS),
      .SEG_BITS  (SEG_BITS),
      .SEG_IDX   (k),
      .DEVICE    (DEVICE)
    ) u_seg (
      .clk     (aclk),
      .aresetn (aresetn),
      .en      (en),
      .in_rec  (rec[k]),
      .out_rec (rec[k+1])
    );
  end

  // Carry into the MSB is recovered as sum^p of that bit.
  assign m_valid     = rec[N_SEG].valid;
  assign m_sum       = rec[N_SEG].sum[DATA_BITS-1:0];
  assign m_carry     = rec[N_SEG].carry;
  assign m_overflow  = rec[N_SEG].carry ^ rec[N_SEG].sum[DATA_BITS-1] ^ rec[N_SEG].p[DATA_BITS-1];
  assign last_unused = rec[N_SEG];

endmodule

// File: doc/jelly3_carry_pipeline_adder.md
JELLY3_CARRY_PIPELINE_ADDER -- requirements
Module: jelly3_carry_pipeline_adder

Interface
REQ-001 SHALL have parameter DATA_BITS, default 32: operand/result width.
REQ-002 SHALL have parameter SEG_BITS, default 8: bits resolved per pipeline stage. N_SEG = ceil(DATA_BITS/SEG_BITS).
REQ-003 SHALL have parameter DEVICE, default "RTL": passed to the carry logic; "RTL" selects generic logic.
REQ-004 SHALL have port aclk, input, 1: single clock; all logic is rising-edge.
REQ-005 SHALL have port aresetn, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port s_a, input, DATA_BITS: operand A.
REQ-007 SHALL have port s_b, input, DATA_BITS: operand B.
REQ-008 SHALL have port s_cin, input, 1: carry-in, ignored when s_sub=1.
REQ-009 SHALL have port s_sub, input, 1: 1 means compute A-B.
REQ-010 SHALL have port s_valid, input, 1: input valid.
REQ-011 SHALL have port s_ready, output, 1: input accepted when s_valid&&s_ready.
REQ-012 SHALL have port m_sum, output, DATA_BITS: result.
REQ-013 SHALL have port m_carry, output, 1: carry-out of the MSB; for subtract, 1 = no borrow.
REQ-014 SHALL have port m_overflow, output, 1: signed overflow.
REQ-015 SHALL have port m_valid, output, 1: output valid.
REQ-016 SHALL have port m_ready, input, 1: downstream accepts when m_valid&&m_ready.

Function
REQ-017 SHALL form per bit: b' = s_sub ? ~s_b : s_b; propagate p = a^b'; generate source d = a; carry-in c0 = s_sub ? 1 : s_cin.
REQ-018 SHALL resolve segment k (bits k*SEG_BITS upward) in stage k, with the carry registered from stage k-1; the last segment is truncated to DATA_BITS.
REQ-019 SHALL skew inputs: upper-segment p/d are delayed k cycles; lower-segment sums are delayed (N_SEG-1-k) cycles, so all sum bits of one transaction emerge together.
REQ-020 SHALL compute sum bit = c^p and next carry = p ? c : d.
REQ-021 SHALL give m_overflow = (carry into MSB) ^ (carry out of MSB).
REQ-022 SHALL have a latency of exactly N_SEG cycles from the accept edge to m_valid, when not stalled.
REQ-023 SHALL advance the pipeline (global enable) when m_ready || !m_valid; with no skid buffer, s_ready equals that enable.
REQ-024 SHALL, while the pipeline is stalled, hold all stage registers, m_* outputs and valid bits unchanged.
REQ-025 SHALL track per-stage valid bits; a bubble (s_valid=0) propagates as an invalid stage and never produces m_valid.
REQ-026 SHALL sustain a throughput of one transaction per cycle with m_ready held at 1.
REQ-027 SHALL generate results at DATA_BITS < SEG_BITS with N_SEG=1.

Reset
REQ-028 SHALL, while aresetn=0 at a clock edge, clear all valid bits; m_valid=0; m_sum=0; m_carry=0; m_overflow=0; s_ready=0 while in reset.
REQ-029 SHALL discard in-flight transactions when reset is asserted mid-operation; the first accept after release yields m_valid exactly N_SEG cycles later.

Configuration
REQ-030 SHALL, with macro JELLY3_CARRY_PIPELINE_ADDER_SKID_EN defined, insert a 2-entry skid buffer at the input, making s_ready a register output (s_ready = skid not full); latency +1 cycle; nothing is lost or duplicated under any m_ready pattern.
REQ-031 SHALL, without the macro, connect input directly per REQ-023, with latency N_SEG.

Structure
REQ-032 SHALL place in package jelly3_carry_pipeline_pkg: function calc_n_seg(DATA_BITS, SEG_BITS), and the typedef of the per-stage record {valid, p, d, sum, carry}.
REQ-033 SHALL implement one registered segment stage as sub-module jelly3_carry_pipeline_segment (SEG_BITS-wide carry resolve plus register, enable input, DEVICE passthrough); it is instantiated N_SEG times.

Verification (DATA_BITS=16, SEG_BITS=8, no macro unless stated)
REQ-034 SHALL test A=0x00FF, B=0x0001, cin=0, sub=0 -> after 2 cycles m_sum=0x0100, m_carry=0, m_overflow=0.
REQ-035 SHALL test A=0xFFFF, B=0x0001 -> m_sum=0x0000, m_carry=1, m_overflow=0; A=0x7FFF, B=0x0001 -> m_sum=0x8000, m_overflow=1.
REQ-036 SHALL test sub=1, A=0x0005, B=0x0007 -> m_sum=0xFFFE, m_carry=0, m_overflow=0.
REQ-037 SHALL stream 100 random back-to-back operations with m_ready randomly toggled -> results in order, match the reference model, no drops, and outputs stable while stalled.
REQ-038 SHALL assert aresetn=0 for 1 cycle with 2 transactions in flight -> m_valid=0, and no stale result appears afterward.
REQ-039 SHALL repeat REQ-037 with JELLY3_CARRY_PIPELINE_ADDER_SKID_EN -> same results, latency 3, and s_ready is registered.
